// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop clock-enable divider with deferred divisor update; CLK_DIV_CTRL_TICK_CNT_EN adds tick_cnt
module clk_div_ctrl #(
  parameter int DIV_W       = 8,
  parameter int DIV_DEFAULT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             tick,
  output logic             div_clk,
  output logic             busy,
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  output logic [CNT_W-1:0] tick_cnt,
`endif
  output logic [DIV_W-1:0] cur_div
);
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;
  state_t state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n, cur_n, pend, pend_n, clamp_div, cnt_inc;
  logic tick_n, dclk_n, xfer, last;
  if (CNT_W < 1 || DIV_DEFAULT < 2 || DIV_DEFAULT > 2**DIV_W-1) begin : g_bad_param
    $error("clk_div_ctrl: illegal parameter value");
  end
  assign cfg_ready = !rst && state != PEND;
  assign xfer      = cfg_valid && cfg_ready;
  assign busy      = state != IDLE;
  assign clamp_div = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
  assign last      = cnt == cur_div - DIV_W'(1);
  assign cnt_inc   = last ? '0 : cnt + DIV_W'(1);
  // state, counter, divisor and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cur_div <= DIV_W'(DIV_DEFAULT);
      pend    <= '0;
      tick    <= 1'b0;
      div_clk <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cur_div <= cur_n;
      pend    <= pend_n;
      tick    <= tick_n;
      div_clk <= dclk_n;
    end
  end
  // next state: a stop or period boundary in PEND commits the waiting divisor
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur_n   = cur_div;
    pend_n  = pend;
    tick_n  = 1'b0;
    dclk_n  = 1'b0;
    if (state == IDLE) begin
      cnt_n   = '0;
      cur_n   = xfer ? clamp_div : cur_div;
      state_n = en ? RUN : IDLE;
    end else if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      cur_n   = (state == PEND) ? pend : (xfer ? clamp_div : cur_div);
    end else begin
      cnt_n  = cnt_inc;
      tick_n = last;
      dclk_n = cnt >= (cur_div >> 1);
      if (state == PEND && last) begin
        cur_n   = pend;
        state_n = RUN;
      end else if (xfer) begin
        pend_n  = clamp_div;
        state_n = PEND;
      end
    end
  end
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  // free-running count of emitted ticks, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) tick_cnt <= '0;
    else if (tick_n) tick_cnt <= tick_cnt + CNT_W'(1);
  end
`endif
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: vector table, directed corner sequences and randomized run against a queue-based model
module tb_clk_div_ctrl;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_div = '0, cur_div;
  logic cfg_ready, tick, div_clk, busy;
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
  logic [15:0] tick_cnt;
`endif
  int n_cmp = 0, n_err = 0;
  bit m_run, m_tick, m_dclk;
  int m_pos, m_n = 16, m_tc, m_rdy;
  int m_pend[$];
  typedef struct {bit r, e, v; int d; bit t, dc, b; int cur; bit rdy;} vec_t;
  vec_t tbl[15];

  clk_div_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .tick(tick), .div_clk(div_clk), .busy(busy),
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    .tick_cnt(tick_cnt),
`endif
    .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_step(input bit r, e, v, input int d);
    bit xf, had;
    int val;
    m_rdy = !r;
    if (r) begin
      m_run = 0; m_pos = 0; m_n = 16; m_pend.delete(); m_tick = 0; m_dclk = 0; m_tc = 0;
      return;
    end
    had = m_pend.size() != 0;
    xf = v && !had;
    val = d < 2 ? 2 : d;
    m_tick = 0; m_dclk = 0;
    if (!m_run) begin
      if (xf) m_n = val;
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (!e) begin
      m_run = 0; m_pos = 0;
      if (had) m_n = m_pend.pop_front();
      else if (xf) m_n = val;
    end else begin
      m_tick = m_pos == m_n - 1;
      m_dclk = m_pos >= m_n / 2;
      if (m_pos == m_n - 1) begin
        m_pos = 0;
        if (had) m_n = m_pend.pop_front();
      end else m_pos++;
      if (xf) m_pend.push_back(val);
    end
    if (m_tick) m_tc = (m_tc + 1) % 65536;
    m_rdy = m_pend.size() == 0;
  endtask

  task automatic cyc(input bit r, e, v, input int d);
    rst = r; en = e; cfg_valid = v; cfg_div = 8'(d);
    @(posedge clk);
    model_step(r, e, v, d);
    #1;
    chk("m_tick", int'(tick), int'(m_tick));
    chk("m_div_clk", int'(div_clk), int'(m_dclk));
    chk("m_busy", int'(busy), int'(m_run));
    chk("m_cur_div", int'(cur_div), m_n);
    chk("m_cfg_ready", int'(cfg_ready), m_rdy);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    chk("m_tick_cnt", int'(tick_cnt), m_tc);
`endif
  endtask

  task automatic wait_tick(input int maxc, output int n);
    n = 0;
    do begin
      cyc(0, 1, 0, 0);
      n++;
    end while (!tick && n < maxc);
  endtask

  initial begin
    int n, hi, tk;
    bit e_r;
    tbl[0]  = '{1,0,0,0, 0,0,0,16,0};
    tbl[1]  = '{0,1,1,0, 0,0,1,2,1};
    tbl[2]  = '{0,1,0,0, 0,0,1,2,1};
    tbl[3]  = '{0,1,0,0, 1,1,1,2,1};
    tbl[4]  = '{0,1,0,0, 0,0,1,2,1};
    tbl[5]  = '{0,1,0,0, 1,1,1,2,1};
    tbl[6]  = '{0,1,1,1, 0,0,1,2,0};
    tbl[7]  = '{0,1,0,0, 1,1,1,2,1};
    tbl[8]  = '{0,0,0,0, 0,0,0,2,1};
    tbl[9]  = '{0,0,1,3, 0,0,0,3,1};
    tbl[10] = '{0,1,0,0, 0,0,1,3,1};
    tbl[11] = '{0,1,0,0, 0,0,1,3,1};
    tbl[12] = '{0,1,0,0, 0,1,1,3,1};
    tbl[13] = '{0,1,0,0, 1,1,1,3,1};
    tbl[14] = '{1,1,0,0, 0,0,0,16,0};
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_tick", i), int'(tick), int'(tbl[i].t));
      chk($sformatf("vec%0d_div_clk", i), int'(div_clk), int'(tbl[i].dc));
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(tbl[i].b));
      chk($sformatf("vec%0d_cur_div", i), int'(cur_div), tbl[i].cur);
      chk($sformatf("vec%0d_cfg_ready", i), int'(cfg_ready), int'(tbl[i].rdy));
    end
    // default divisor: period 16, 8 low / 8 high
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    wait_tick(40, n); chk("A_first_gap", n, 16);
    wait_tick(40, n); chk("A_gap", n, 16);
    hi = 0;
    for (int i = 0; i < 16; i++) begin cyc(0, 1, 0, 0); hi += int'(div_clk); end
    chk("A_high_cycles", hi, 8);
    chk("A_busy", int'(busy), 1);
    // divisor 5 programmed in IDLE: period 5, 2 low / 3 high
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 5);
    chk("B_cur_div", int'(cur_div), 5);
    cyc(0, 1, 0, 0);
    wait_tick(20, n); chk("B_first_gap", n, 5);
    hi = 0; tk = 0;
    for (int i = 0; i < 5; i++) begin cyc(0, 1, 0, 0); hi += int'(div_clk); tk += int'(tick); end
    chk("B_high_cycles", hi, 3);
    chk("B_ticks", tk, 1);
    chk("B_cfg_ready", int'(cfg_ready), 1);
    // divisor 4 offered at cnt=3 while running at 16
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 4);
    chk("C_ready_low", int'(cfg_ready), 0);
    chk("C_cur_kept", int'(cur_div), 16);
    wait_tick(40, n); chk("C_closing_gap", n, 12);
    chk("C_cur_new", int'(cur_div), 4);
    chk("C_ready_back", int'(cfg_ready), 1);
    wait_tick(40, n); chk("C_gap4a", n, 4);
    wait_tick(40, n); chk("C_gap4b", n, 4);
    // stop at cnt=7 with N=10 and 3 pending
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 10);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 3);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("E_busy", int'(busy), 0);
    chk("E_tick", int'(tick), 0);
    chk("E_div_clk", int'(div_clk), 0);
    chk("E_cur_div", int'(cur_div), 3);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    wait_tick(20, n); chk("E_restart_gap", n, 3);
    // reset while a divisor of 20 is pending at N=8
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 8);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 20);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("F_cur_div", int'(cur_div), 16);
    chk("F_busy", int'(busy), 0);
    chk("F_tick", int'(tick), 0);
    chk("F_div_clk", int'(div_clk), 0);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
    chk("F_tick_cnt0", int'(tick_cnt), 0);
`endif
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      wait_tick(40, n);
      chk("F_gap", n, 16);
`ifdef CLK_DIV_CTRL_TICK_CNT_EN
      chk("F_tick_cnt", int'(tick_cnt), i);
`endif
    end
    // randomized traffic against the model
    cyc(1, 0, 0, 0);
    e_r = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) e_r = !e_r;
      cyc($urandom_range(0, 199) == 0, e_r, $urandom_range(0, 5) == 0,
          $urandom_range(0, 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 255)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
